// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared types for the convolution engine output transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int PIX_TX_STALL_W = 16;
    localparam int PIX_TX_PIX_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } tx_state_e;

    // Reference entry layout at the default pixel width; the transmitter
    // uses the same field order resized to its PIX_BITS.
    typedef struct packed {
        logic [PIX_TX_PIX_W-1:0] data;
        logic                    lastx;
        logic                    lasty;
    } pix_tx_entry_t;

endpackage
`default_nettype wire

// File: rtl/pix_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pix_fifo
//  Description : Synchronous FIFO with combinational head output.
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign o_rdata = r_mem[r_rd_ptr[c_ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pix_out_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pix_out_tx
//  Description : Pixel stream transmitter with row/frame tagging and done.
//                Optional stall counter enabled by PIX_TX_STALL_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pix_out_tx
    import conv_pkg::*;
#(
    parameter int XMAX_BITS  = 10,
    parameter int YMAX_BITS  = 10,
    parameter int PIX_BITS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XMAX_BITS-1:0] img_width,
    input  logic [YMAX_BITS-1:0] img_height,
    input  logic                 start,
    input  logic [PIX_BITS-1:0]  eng_data,
    input  logic                 eng_valid,
    output logic                 eng_rdy,
    output logic [PIX_BITS-1:0]  pix_out_data,
    output logic                 pix_out_valid,
    input  logic                 pix_out_rdy,
    output logic                 pix_out_lastx,
    output logic                 pix_out_lasty,
    output logic                 done,
`ifdef PIX_TX_STALL_CNT_EN
    output logic                 busy,
    output logic [PIX_TX_STALL_W-1:0] stall_cnt
`else
    output logic                 busy
`endif
);

    typedef struct packed {
        logic [PIX_BITS-1:0] data;
        logic                lastx;
        logic                lasty;
    } entry_t;

    tx_state_e            r_state;
    logic [XMAX_BITS-1:0] r_w_m1;
    logic [YMAX_BITS-1:0] r_h_m1;
    logic [XMAX_BITS-1:0] r_col;
    logic [YMAX_BITS-1:0] r_row;
    logic                 r_busy;
    logic                 r_done;

    entry_t               w_push_entry;
    entry_t               w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_lastx;
    logic                 w_lasty;

    assign w_lastx      = (r_col == r_w_m1);
    assign w_lasty      = (r_row == r_h_m1);
    assign eng_rdy      = (r_state == RUN) && !w_full;
    assign w_push       = eng_valid && eng_rdy;
    assign w_push_entry = {eng_data, w_lastx, w_lasty};

    assign pix_out_valid = !w_empty;
    assign w_pop         = pix_out_valid && pix_out_rdy;

    // The FIFO storage is not reset, so mask the head while empty.
    assign pix_out_data  = w_empty ? '0 : w_head.data;
    assign pix_out_lastx = !w_empty && w_head.lastx;
    assign pix_out_lasty = !w_empty && w_head.lasty;

    assign busy = r_busy;
    assign done = r_done;

    pix_fifo #(
        .WIDTH (PIX_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_w_m1  <= '0;
            r_h_m1  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_w_m1 <= img_width - 1'b1;
                        r_h_m1 <= img_height - 1'b1;
                        r_col  <= '0;
                        r_row  <= '0;
                        if ((img_width == '0) || (img_height == '0)) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_push) begin
                        if (w_lastx) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                        if (w_lastx && w_lasty) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The frame-final entry is the last one pushed, so its
                    // pop also empties the FIFO.
                    if (w_pop && w_head.lastx && w_head.lasty) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef PIX_TX_STALL_CNT_EN
    logic [PIX_TX_STALL_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if (r_busy && pix_out_valid && !pix_out_rdy && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
